// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter
//   Shares one ALU datapath (cmp / add / subt) between two requesters.
//   Round-robin arbitration; the winner's operation and operands are latched
//   and driven onto the ALU for LAT cycles, then the result is captured on
//   res_o and a one-cycle done pulse goes back to the winner.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN/opN/aN/bN          requester N request (level), op, operands
//   gntN, doneN             one-cycle accept / result-valid pulses
//   alu_x, alu_y, alu_sel   ALU operands and active-low one-hot select
//   alu_res                 ALU result
//   res_o                   last captured result
//   busy                    high whenever the FSM is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ALU parked (sel 111, x/y 0), waiting for a request
// WAIT  | ALU driven with the latched job, counting down LAT cycles
// DONE  | result on res_o, done pulse to winner, rr pointer flips
module alu_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int RES_W = 13,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_sel,
  input  logic [RES_W-1:0] alu_res,
  output logic [RES_W-1:0] res_o,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]       sel_q, sel_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             win;

  function automatic logic [2:0] sel_enc(input logic [1:0] op);
    case (op)
      2'b01:   sel_enc = 3'b110;
      2'b10:   sel_enc = 3'b101;
      2'b11:   sel_enc = 3'b011;
      default: sel_enc = 3'b111;
    endcase
  endfunction

  // Contention goes to the rr pointer; otherwise whoever is requesting.
  assign win = (req0 & req1) ? rr_q : req1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        x_d   = '0;
        y_d   = '0;
        sel_d = 3'b111;
        if (req0 | req1) begin
          id_d    = win;
          x_d     = win ? a1 : a0;
          y_d     = win ? b1 : b0;
          sel_d   = sel_enc(win ? op1 : op0);
          gnt0_d  = ~win;
          gnt1_d  = win;
          cnt_d   = 4'(LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_res;
          done0_d = ~id_q;
          done1_d = id_q;
          x_d     = '0;
          y_d     = '0;
          sel_d   = 3'b111;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rr_d    = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= 3'b111;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign alu_x   = x_q;
  assign alu_y   = y_q;
  assign alu_sel = sel_q;
  assign res_o   = res_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
module tb_alu_op_arbiter;
  localparam int LAT = 4;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic [1:0]  op  [2];
  logic [7:0]  a   [2];
  logic [7:0]  b   [2];
  logic        gnt0, gnt1, done0, done1, busy;
  logic [7:0]  alu_x, alu_y;
  logic [2:0]  alu_sel;
  logic [12:0] alu_res, res_o;

  int tests = 0;
  int fails = 0;

  job_t q0[$];
  job_t q1[$];

  always #5 clk = ~clk;

  alu_op_arbiter #(.WIDTH(8), .RES_W(13), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .op0(op[0]), .a0(a[0]), .b0(b[0]), .gnt0(gnt0), .done0(done0),
    .req1(req[1]), .op1(op[1]), .a1(a[1]), .b1(b[1]), .gnt1(gnt1), .done1(done1),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_res(alu_res),
    .res_o(res_o), .busy(busy)
  );

  // ALU stub: LAT-1 register stages, so a result reflects inputs held LAT cycles.
  logic [12:0] p1 = '0, p2 = '0, p3 = '0;
  function automatic logic [12:0] cmp_code(input logic [7:0] x, input logic [7:0] y);
    if (x < y) return 13'd1;
    if (x == y) return 13'd2;
    return 13'd4;
  endfunction
  always @(posedge clk) begin
    case (alu_sel)
      3'b111:  p1 <= 13'd0;
      3'b110:  p1 <= cmp_code(alu_x, alu_y);
      3'b101:  p1 <= {5'd0, alu_x} + {5'd0, alu_y};
      3'b011:  p1 <= {5'd0, alu_x} - {5'd0, alu_y};
      default: p1 <= 13'h1555;
    endcase
    p2 <= p1;
    p3 <= p2;
  end
  assign alu_res = p3;

  function automatic logic [12:0] exp_res(input job_t j);
    case (j.op)
      2'b00:   return 13'd0;
      2'b01:   return cmp_code(j.a, j.b);
      2'b10:   return 13'(j.a) + 13'(j.b);
      default: return 13'(j.a) - 13'(j.b);
    endcase
  endfunction

  function automatic logic [2:0] exp_sel(input logic [1:0] o);
    case (o)
      2'b00:   return 3'b111;
      2'b01:   return 3'b110;
      2'b10:   return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  bit          in_job = 0, rr = 0, aid = 0, pr0 = 0, pr1 = 0, gid, expw;
  int          wcnt = 0;
  logic [12:0] res_prev = '0;
  job_t        cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_job = 0; rr = 0; res_prev = '0; pr0 = 0; pr1 = 0;
      q0.delete(); q1.delete();
    end else begin
      if (gnt0 || gnt1) begin
        check_eq("gnt_onehot", {31'd0, gnt0 && gnt1}, 0);
        check_eq("gnt_while_busy", {31'd0, in_job}, 0);
        gid  = gnt1;
        expw = (pr0 && pr1) ? rr : (pr1 && !pr0);
        check_eq("gnt_req_present", {31'd0, pr0 || pr1}, 1);
        check_eq("gnt_winner", {31'd0, gid}, {31'd0, expw});
        check_eq("gnt_job_queued", gid ? q1.size() : q0.size(), 1);
        if (gid ? (q1.size() > 0) : (q0.size() > 0)) cur = gid ? q1[0] : q0[0];
        in_job = 1; aid = gid; wcnt = 0;
      end
      check_eq("busy", {31'd0, busy}, {31'd0, in_job});
      if (done0 || done1) begin
        check_eq("done_onehot", {31'd0, done0 && done1}, 0);
        check_eq("done_in_job", {31'd0, in_job}, 1);
        check_eq("done_id", {31'd0, done1}, {31'd0, aid});
        check_eq("wait_cycles", wcnt, LAT);
        check_eq("res_o", {19'd0, res_o}, {19'd0, exp_res(cur)});
        check_eq("done_sel_park", {29'd0, alu_sel}, 32'h7);
        check_eq("done_xy_park", {16'd0, alu_x, alu_y}, 0);
        if (aid == 0 && q0.size() > 0) void'(q0.pop_front());
        if (aid == 1 && q1.size() > 0) void'(q1.pop_front());
        rr = !aid; in_job = 0; res_prev = res_o;
      end else begin
        check_eq("res_hold", {19'd0, res_o}, {19'd0, res_prev});
        if (in_job) begin
          wcnt++;
          check_eq("wait_x", {24'd0, alu_x}, {24'd0, cur.a});
          check_eq("wait_y", {24'd0, alu_y}, {24'd0, cur.b});
          check_eq("wait_sel", {29'd0, alu_sel}, {29'd0, exp_sel(cur.op)});
        end else begin
          check_eq("idle_sel", {29'd0, alu_sel}, 32'h7);
        end
      end
      pr0 = req[0]; pr1 = req[1];
    end
  end

  task automatic run_job(input int id, input job_t j, input bit scramble);
    bit got;
    @(posedge clk); #1;
    if (id == 0) q0.push_back(j); else q1.push_back(j);
    req[id] = 1'b1; op[id] = j.op; a[id] = j.a; b[id] = j.b;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = (id == 0) ? gnt0 : gnt1;
    end
    check_eq("gnt_timeout", {31'd0, got}, 1);
    if (got) begin
      @(posedge clk); #1;
      if (scramble) begin
        a[id] = 8'hFF; b[id] = 8'($urandom); op[id] = 2'($urandom);
      end
      got = 0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(negedge clk);
        got = (id == 0) ? done0 : done1;
      end
      check_eq("done_timeout", {31'd0, got}, 1);
    end
    @(posedge clk); #1;
    req[id] = 1'b0;
  endtask

  task automatic rand_stream(input int id, input int njobs);
    job_t j;
    for (int k = 0; k < njobs; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      j.op = 2'($urandom); j.a = 8'($urandom); j.b = 8'($urandom);
      run_job(id, j, 1'($urandom));
    end
  endtask

  job_t jx, jy;
  int   dcount;
  bit   got;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; op[i] = 0; a[i] = 0; b[i] = 0;
    end
    // Reset held with a request pending
    req[0] = 1; op[0] = 2'b10; a[0] = 8'h01; b[0] = 8'h02;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {26'd0, gnt0, gnt1, done0, done1, busy, 1'b0}, 0);
    check_eq("rst_sel", {29'd0, alu_sel}, 32'h7);
    check_eq("rst_xy_res", {3'd0, alu_x, alu_y, res_o}, 0);
    @(posedge clk); #1;
    jx.op = 2'b10; jx.a = 8'h01; jx.b = 8'h02;
    q0.push_back(jx);
    rst_n = 1;
    @(negedge clk);
    check_eq("rst_rel_gnt_early", {31'd0, gnt0}, 0);
    @(negedge clk);
    check_eq("rst_rel_gnt0", {31'd0, gnt0}, 1);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = done0; end
    check_eq("rst_rel_done0", {31'd0, got}, 1);
    @(posedge clk); #1; req[0] = 0;
    repeat (2) @(posedge clk);

    // Single add
    jx.op = 2'b10; jx.a = 8'h25; jx.b = 8'h13;
    run_job(0, jx, 0);
    check_eq("add_res", {19'd0, res_o}, 32'h38);
    repeat (2) @(posedge clk);

    // Simultaneous cmp (req0) and subt (req1); rr currently favours 1 after job 0
    // served last, so first serve req1 alone to bring the pointer back to 0.
    jx.op = 2'b00; jx.a = 8'h00; jx.b = 8'h00;
    run_job(1, jx, 0);
    repeat (2) @(posedge clk);
    jx.op = 2'b01; jx.a = 8'h40; jx.b = 8'h41;
    jy.op = 2'b11; jy.a = 8'h10; jy.b = 8'h30;
    fork
      run_job(0, jx, 0);
      run_job(1, jy, 0);
    join
    repeat (2) @(posedge clk);

    // Requester 1 continuously contending with back-to-back requester 0 jobs
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          jx.op = 2'b10; jx.a = 8'(k * 17); jx.b = 8'h05; run_job(0, jx, 0);
        end
      end
      begin
        jy.op = 2'b11; jy.a = 8'h02; jy.b = 8'h09; run_job(1, jy, 0);
      end
    join
    repeat (2) @(posedge clk);

    // Operand change after grant
    jx.op = 2'b10; jx.a = 8'h10; jx.b = 8'h22;
    run_job(0, jx, 1);
    check_eq("opchg_res", {19'd0, res_o}, 32'h32);
    repeat (2) @(posedge clk);

    // Reset during the second WAIT cycle
    @(posedge clk); #1;
    req[0] = 1; op[0] = 2'b10; a[0] = 8'h33; b[0] = 8'h44;
    jx.op = 2'b10; jx.a = 8'h33; jx.b = 8'h44;
    q0.push_back(jx);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = gnt0; end
    check_eq("midrst_gnt0", {31'd0, got}, 1);
    @(posedge clk); #1;
    rst_n = 0; req[0] = 0;
    #1;
    check_eq("midrst_sel_async", {29'd0, alu_sel}, 32'h7);
    check_eq("midrst_res_async", {19'd0, res_o}, 0);
    check_eq("midrst_x_busy", {23'd0, alu_x, busy}, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    dcount = 0;
    for (int n = 0; n < 10; n++) begin @(negedge clk); if (done0 || done1) dcount++; end
    check_eq("midrst_no_done", dcount, 0);

    // Randomized concurrent traffic
    fork
      rand_stream(0, 15);
      rand_stream(1, 15);
    join
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
